// File: rtl/qdec_pkg.sv
// Shared types and Gray-code helpers for the quadrature decoder.
package qdec_pkg;

    // Decoder control: INIT primes the filters, TRACK decodes.
    typedef enum logic {INIT, TRACK} qdec_state_e;

    // Filtered {a,b} phases in up order: 00 -> 10 -> 11 -> 01 -> 00.
    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    // INIT cycle count at which the filters are loaded, and the one after,
    // when phase has picked up the loaded value and decode can start.
    localparam logic [1:0] INIT_LOAD = 2'd2;
    localparam logic [1:0] INIT_DONE = 2'd3;

    // Successor of a phase when the encoder turns in the up direction.
    function automatic logic [1:0] next_up(input logic [1:0] ph);
        case (ph)
            PH_00:   next_up = PH_10;
            PH_10:   next_up = PH_11;
            PH_11:   next_up = PH_01;
            default: next_up = PH_00;
        endcase
    endfunction

endpackage

// File: rtl/qdec_filter.sv
// One encoder channel: 2-flop synchroniser followed by a glitch filter that
// accepts a new level only after FILTER_LEN consecutive synchronised samples.
module qdec_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in,
    input  logic load,
    output logic out
);

    logic       s1, s2;
    logic [3:0] cnt;

    // Synchronise the asynchronous channel into the clk domain.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= in;
            s2 <= s1;
        end
    end

    // Count how long s2 has disagreed with the accepted level; any agreeing
    // sample restarts the count, so short pulses never get through.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out <= 1'b0;
            cnt <= 4'd0;
        end else if (load) begin
            out <= s2;
            cnt <= 4'd0;
        end else if (s2 == out) begin
            cnt <= 4'd0;
        end else if (cnt == 4'(FILTER_LEN - 1)) begin
            out <= s2;
            cnt <= 4'd0;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder front end: per-channel sync + glitch filter, Gray decode
// into step/up_down for a downstream up/down counter, illegal-transition flag
// and saturating error count.
// Build option: define QDEC_X4_EN for x4 decoding (step on every legal
// transition); otherwise x1 (step only on entry to 00).
module quad_decoder
    import qdec_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clr_err,
    output logic             step,
    output logic             up_down,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       phase
);

    qdec_state_e state_q, state_d;
    logic [1:0]  init_cnt_q, init_cnt_d;
    logic        load;
    logic [1:0]  enc, filt, diff;
    logic        step_d, err_d, dir_d;

    assign enc = {enc_a, enc_b};

    // Bit 1 is channel A, bit 0 is channel B.
    for (genvar i = 0; i < 2; i++) begin : g_ch
        qdec_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
            .clk     (clk),
            .reset_n (reset_n),
            .in      (enc[i]),
            .load    (load),
            .out     (filt[i])
        );
    end

    // State register for the INIT/TRACK controller.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= INIT;
            init_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Two cycles flush the sync chain, then the filters load s2 directly;
    // one more cycle lets phase catch the loaded value so the first TRACK
    // compare sees no change.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        load       = 1'b0;
        case (state_q)
            INIT: begin
                init_cnt_d = init_cnt_q + 2'd1;
                if (init_cnt_q == INIT_LOAD) begin
                    load = 1'b1;
                end
                if (init_cnt_q == INIT_DONE) begin
                    state_d    = TRACK;
                    init_cnt_d = 2'd0;
                end
            end
            default: ;
        endcase
    end

    // Compare this cycle's filtered phase with last cycle's (held in phase).
    always_comb begin
        step_d = 1'b0;
        err_d  = 1'b0;
        dir_d  = (filt == next_up(phase));
        diff   = filt ^ phase;
        if (state_q == TRACK) begin
            if (diff == 2'b11) begin
                err_d = 1'b1;
            end else if (diff != 2'b00) begin
`ifdef QDEC_X4_EN
                step_d = 1'b1;
`else
                step_d = (filt == PH_00);
`endif
            end
        end
    end

    // Register decode results; direction only moves together with a step.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            step    <= 1'b0;
            err     <= 1'b0;
            up_down <= 1'b1;
            phase   <= PH_00;
        end else begin
            step  <= step_d;
            err   <= err_d;
            phase <= filt;
            if (step_d) begin
                up_down <= dir_d;
            end
        end
    end

    // Saturating illegal-transition count; a clear wins over an increment.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= '0;
        end else if (err_d && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed and random encoder motion,
// checked cycle by cycle against an event-level reference model.
module tb_quad_decoder;

    localparam int FL    = 4;
    localparam int ERR_W = 8;
    localparam int CMAX  = (1 << ERR_W) - 1;
`ifdef QDEC_X4_EN
    localparam int STEPS_PER_REV = 4;
`else
    localparam int STEPS_PER_REV = 1;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             enc_a = 1'b0;
    logic             enc_b = 1'b0;
    logic             clr_err = 1'b0;
    logic             step, up_down, err;
    logic [ERR_W-1:0] err_cnt;
    logic [1:0]       phase;

    quad_decoder #(.FILTER_LEN(FL), .ERR_W(ERR_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .clr_err (clr_err),
        .step    (step),
        .up_down (up_down),
        .err     (err),
        .err_cnt (err_cnt),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    // Expected output activity for one cycle, keyed by clock-edge number.
    typedef struct {
        bit         st;
        bit         er;
        bit         dir;
        int         cnt;
        logic [1:0] ph;
    } ev_t;

    ev_t        evq[int];
    int         cyc = 0;
    int         n_chk = 0, n_fail = 0;
    int         n_step = 0, n_err = 0;
    logic [1:0] mph = 2'b00;
    int         m_cnt = 0;
    logic [1:0] upseq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int gpos(input logic [1:0] p);
        int r = 0;
        for (int i = 0; i < 4; i++) if (upseq[i] == p) r = i;
        return r;
    endfunction

    // Every cycle: outputs must match the scheduled event, or be idle.
    always @(negedge clk) begin : mon
        ev_t e;
        if (evq.exists(cyc)) begin
            e = evq[cyc];
            evq.delete(cyc);
            chk("ev_step", step, e.st);
            chk("ev_err", err, e.er);
            chk("ev_phase", phase, e.ph);
            if (e.st) chk("ev_dir", up_down, e.dir);
            if (e.er) chk("ev_err_cnt", err_cnt, e.cnt);
        end else begin
            chk("idle_step", step, 1'b0);
            chk("idle_err", err, 1'b0);
        end
        n_step += int'(step);
        n_err  += int'(err);
    end

    task automatic hold(input int h);
        repeat (h - 1) @(posedge clk);
    endtask

    // Drive a new stable level and schedule its expected effect FL+3 edges on.
    task automatic move(input logic [1:0] v, input bit clr_at_ev);
        int         ev_cyc;
        ev_t        e;
        logic [1:0] d;
        @(posedge clk); #1;
        {enc_a, enc_b} = v;
        ev_cyc = cyc + FL + 3;
        d = v ^ mph;
        e.st = 1'b0; e.er = 1'b0; e.dir = 1'b0; e.cnt = m_cnt; e.ph = v;
        if (d == 2'b11) begin
            e.er  = 1'b1;
            m_cnt = clr_at_ev ? 0 : ((m_cnt >= CMAX) ? CMAX : m_cnt + 1);
            e.cnt = m_cnt;
        end else if (d != 2'b00) begin
            e.st  = (STEPS_PER_REV == 4) ? 1'b1 : (v == 2'b00);
            e.dir = (gpos(v) == (gpos(mph) + 1) % 4);
        end
        mph = v;
        evq[ev_cyc] = e;
        if (clr_at_ev) begin
            while (cyc < ev_cyc - 1) begin @(posedge clk); #1; end
            clr_err = 1'b1;
            @(posedge clk); #1;
            clr_err = 1'b0;
        end
    endtask

    // Pulse one channel for g (< FL) cycles; it must be filtered out.
    task automatic glitch(input bit ch_a, input int g);
        @(posedge clk); #1;
        {enc_a, enc_b} = mph ^ (ch_a ? 2'b10 : 2'b01);
        repeat (g) @(posedge clk);
        #1;
        {enc_a, enc_b} = mph;
        repeat (FL + 2) @(posedge clk);
    endtask

    task automatic do_reset(input logic [1:0] v);
        @(posedge clk); #1;
        reset_n = 1'b0;
        {enc_a, enc_b} = v;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_step", step, 1'b0);
        chk("rst_up_down", up_down, 1'b1);
        chk("rst_err", err, 1'b0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_phase", phase, 2'b00);
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("init_phase", phase, v);
        mph   = v;
        m_cnt = 0;
    endtask

    initial begin
        int s0, e0, r, h;
        logic [1:0] v;

        // Power-up with both channels high: INIT loads 11 quietly.
        do_reset(2'b11);
        repeat (10) @(posedge clk);
        #1;
        chk("idle11_phase", phase, 2'b11);
        chk("idle11_steps", n_step, 0);
        chk("idle11_errs", n_err, 0);
        chk("idle11_err_cnt", err_cnt, 0);

        // One full revolution up, then down.
        do_reset(2'b00);
        s0 = n_step;
        move(2'b10, 0); hold(10);
        move(2'b11, 0); hold(10);
        move(2'b01, 0); hold(10);
        move(2'b00, 0); hold(10);
        chk("up_steps", n_step - s0, STEPS_PER_REV);
        chk("up_dir", up_down, 1'b1);
        s0 = n_step;
        move(2'b01, 0); hold(10);
        move(2'b11, 0); hold(10);
        move(2'b10, 0); hold(10);
        move(2'b00, 0); hold(10);
        chk("dn_steps", n_step - s0, STEPS_PER_REV);
        chk("dn_dir", up_down, 1'b0);

        // Short glitch on A at rest.
        s0 = n_step; e0 = n_err;
        glitch(1'b1, FL - 1);
        #1;
        chk("glitch_phase", phase, 2'b00);
        chk("glitch_steps", n_step - s0, 0);
        chk("glitch_errs", n_err - e0, 0);

        // 300 simultaneous double toggles: count saturates.
        s0 = n_step; e0 = n_err;
        for (int i = 0; i < 300; i++) begin
            move(mph ^ 2'b11, 0);
            hold(FL + 1);
        end
        repeat (FL + 6) @(posedge clk);
        #1;
        chk("dbl_errs", n_err - e0, 300);
        chk("dbl_sat", err_cnt, CMAX);
        chk("dbl_steps", n_step - s0, 0);
        @(posedge clk); #1;
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        chk("clr_err_cnt", err_cnt, 0);
        m_cnt = 0;
        // Clear coinciding with an error: error still flags, count stays 0.
        move(mph ^ 2'b11, 1); hold(FL + 2);
        move(mph ^ 2'b11, 0); hold(FL + 6);

        // Random motion: legal single steps, illegal jumps, glitches.
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            h = $urandom_range(FL, FL + 4);
            if (r < 6) begin
                v = mph ^ (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
                move(v, 0); hold(h);
            end else if (r < 8) begin
                move(mph ^ 2'b11, 0); hold(h);
            end else begin
                glitch($urandom_range(0, 1) == 1, $urandom_range(1, FL - 1));
            end
        end
        repeat (FL + 6) @(posedge clk);
        #1;
        chk("ev_drain", evq.size(), 0);
        chk("rand_phase", phase, mph);

        // Reset in the middle of filtering an A edge.
        do_reset(2'b00);
        s0 = n_step; e0 = n_err;
        @(posedge clk); #1;
        enc_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_phase", phase, 2'b10);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_steps", n_step - s0, 0);
        chk("abort_errs", n_err - e0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
